// File: rtl/mul_div_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: op codes, FSM states,
// divide latency (32 restoring steps plus one sign-fix/commit cycle).
package mul_div_pkg;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;
   localparam logic [2:0] OP_MADD  = 3'd6;
   localparam logic [2:0] OP_MADDU = 3'd7;

   localparam int DIV_LATENCY = 33;
   localparam int DIV_STEPS   = DIV_LATENCY - 1;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

endpackage

// File: rtl/mul_div_div_core.sv
// Iterative radix-2 restoring unsigned divider: load magnitudes, 32 shift/subtract
// steps, one-cycle done pulse while quotient/remainder are held stable.
module mul_div_div_core import mul_div_pkg::*; (
   input  logic        clk,
   input  logic        reset,
   input  logic        load_i,
   input  logic [31:0] dividend_i,
   input  logic [31:0] divisor_i,
   output logic [31:0] quo_o,
   output logic [31:0] rem_o,
   output logic        done_o
);

   logic [31:0] quo_q, rem_q, dvs_q;
   logic [5:0]  cnt_q;
   logic        done_q;
   logic [32:0] shifted, diff;
   logic        ge;
   logic [31:0] quo_d, rem_d;

   // rem_q < divisor keeps the shifted value inside 33 bits, so bit 32 of the
   // difference is a clean borrow flag (divisor 0 always "fits").
   always_comb begin
      shifted = {rem_q, quo_q[31]};
      diff    = shifted - {1'b0, dvs_q};
      ge      = ~diff[32];
      rem_d   = ge ? diff[31:0] : shifted[31:0];
      quo_d   = {quo_q[30:0], ge};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         quo_q  <= '0;
         rem_q  <= '0;
         dvs_q  <= '0;
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else if (load_i) begin
         quo_q  <= dividend_i;
         rem_q  <= '0;
         dvs_q  <= divisor_i;
         cnt_q  <= 6'(DIV_STEPS);
         done_q <= 1'b0;
      end else if (cnt_q != 6'd0) begin
         quo_q  <= quo_d;
         rem_q  <= rem_d;
         cnt_q  <= cnt_q - 6'd1;
         done_q <= (cnt_q == 6'd1);
      end else begin
         done_q <= 1'b0;
      end
   end

   assign quo_o  = quo_q;
   assign rem_o  = rem_q;
   assign done_o = done_q;

endmodule

// File: rtl/mul_div_unit.sv
// HI/LO owning multiply/divide unit for the E stage. Define MUL_DIV_MADD_EN to
// enable MADD/MADDU accumulation; otherwise ops 6/7 are accepted as no-ops.
module mul_div_unit import mul_div_pkg::*; #(
   parameter int MULT_CYCLES = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   state_t      state_q;
   logic [4:0]  cnt_q;
   logic [63:0] prod_q, prod_d;
   logic [31:0] hi_q, lo_q, a_q;
   logic        qneg_q, rneg_q, dz_q;
`ifdef MUL_DIV_MADD_EN
   logic        acc_q;
`endif

   logic        sgn_mul, sgn_div, div_load, div_done;
   logic [31:0] a_mag, b_mag, quo, rem, quo_fix, rem_fix;

   // One 64x64 multiplier serves both signednesses: sign-extend or zero-extend
   // the operands and keep the low 64 bits.
   always_comb begin
      sgn_mul  = (op == OP_MULT) || (op == OP_MADD);
      sgn_div  = (op == OP_DIV);
      prod_d   = {{32{sgn_mul & a[31]}}, a} * {{32{sgn_mul & b[31]}}, b};
      a_mag    = (sgn_div && a[31]) ? -a : a;
      b_mag    = (sgn_div && b[31]) ? -b : b;
      div_load = start && (state_q == S_IDLE) && ((op == OP_DIV) || (op == OP_DIVU));
      quo_fix  = qneg_q ? -quo : quo;
      rem_fix  = rneg_q ? -rem : rem;
   end

   mul_div_div_core u_div (
      .clk        (clk),
      .reset      (reset),
      .load_i     (div_load),
      .dividend_i (a_mag),
      .divisor_i  (b_mag),
      .quo_o      (quo),
      .rem_o      (rem),
      .done_o     (div_done)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         prod_q  <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         a_q     <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         dz_q    <= 1'b0;
`ifdef MUL_DIV_MADD_EN
         acc_q   <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            S_IDLE: if (start) begin
               case (op)
                  OP_MULT, OP_MULTU: begin
                     prod_q  <= prod_d;
                     cnt_q   <= 5'(MULT_CYCLES);
                     state_q <= S_MUL;
`ifdef MUL_DIV_MADD_EN
                     acc_q   <= 1'b0;
`endif
                  end
`ifdef MUL_DIV_MADD_EN
                  OP_MADD, OP_MADDU: begin
                     prod_q  <= prod_d;
                     cnt_q   <= 5'(MULT_CYCLES);
                     state_q <= S_MUL;
                     acc_q   <= 1'b1;
                  end
`endif
                  OP_DIV, OP_DIVU: begin
                     qneg_q  <= sgn_div & (a[31] ^ b[31]);
                     rneg_q  <= sgn_div & a[31];
                     dz_q    <= (b == 32'd0);
                     a_q     <= a;
                     state_q <= S_DIV;
                  end
                  OP_MTHI: hi_q <= a;
                  OP_MTLO: lo_q <= a;
                  default: ;
               endcase
            end
            S_MUL: begin
               cnt_q <= cnt_q - 5'd1;
               if (cnt_q == 5'd1) begin
`ifdef MUL_DIV_MADD_EN
                  {hi_q, lo_q} <= acc_q ? ({hi_q, lo_q} + prod_q) : prod_q;
`else
                  {hi_q, lo_q} <= prod_q;
`endif
                  state_q <= S_IDLE;
               end
            end
            S_DIV: if (div_done) begin
               // Divide by zero returns the raw dividend, not the sign-fixed magnitude.
               lo_q    <= dz_q ? 32'hFFFF_FFFF : quo_fix;
               hi_q    <= dz_q ? a_q : rem_fix;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy = (state_q != S_IDLE);
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases, busy-window latency,
// reset abort, MADD option and randomized ops against an arithmetic model.
module tb_mul_div_unit;

   localparam int MC = 5;

   logic        clk = 1'b0;
   logic        reset, start;
   logic [2:0]  op;
   logic [31:0] a, b;
   logic        busy;
   logic [31:0] hi, lo;

   int n_cmp = 0;
   int n_bad = 0;
   logic [63:0] mhl;   // model {hi,lo}

   mul_div_unit #(.MULT_CYCLES(MC)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, y,
                                         input logic [63:0] hl);
      int sx, sy;
      longint sp;
      logic [63:0] up;
      sx = x; sy = y;
      sp = longint'(sx) * longint'(sy);
      up = 64'(x) * 64'(y);
      case (o)
         3'd0: return sp;
         3'd1: return up;
         3'd2: begin
            if (y == 0) return {x, 32'hFFFF_FFFF};
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            return {32'(sx % sy), 32'(sx / sy)};
         end
         3'd3: begin
            if (y == 0) return {x, 32'hFFFF_FFFF};
            return {x % y, x / y};
         end
         3'd4: return {x, hl[31:0]};
         3'd5: return {hl[63:32], x};
`ifdef MUL_DIV_MADD_EN
         3'd6: return hl + sp;
         3'd7: return hl + up;
`endif
         default: return hl;
      endcase
   endfunction

   function automatic int lat_of(input logic [2:0] o);
      case (o)
         3'd0, 3'd1: return MC;
         3'd2, 3'd3: return 33;
`ifdef MUL_DIV_MADD_EN
         3'd6, 3'd7: return MC;
`endif
         default: return 0;
      endcase
   endfunction

   // Drive one start, scramble inputs during busy, count busy cycles (bounded)
   // and note any HI/LO movement before the commit.
   task automatic issue(input logic [2:0] o, input logic [31:0] x, y,
                        output int nb, output bit chg);
      logic [31:0] h0, l0;
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      h0 = hi; l0 = lo;
      @(posedge clk); #1;
      start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
      nb = 0; chg = 1'b0;
      while (busy === 1'b1 && nb < 200) begin
         if (hi !== h0 || lo !== l0) chg = 1'b1;
         nb++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      mhl = '0;
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
      n_cmp++; if (hi !== 32'h0) begin n_bad++; $display("FAIL reset_hi got %h want 0", hi); end
      n_cmp++; if (lo !== 32'h0) begin n_bad++; $display("FAIL reset_lo got %h want 0", lo); end
   endtask

   task automatic test_directed;
      logic [2:0]  ops [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd2, 3'd2};
      logic [31:0] as  [6] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd7,
                               32'h8000_0000, 32'hFFFF_FFFB};
      logic [31:0] bs  [6] = '{32'd3, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'd0};
      logic [31:0] eh  [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd7,
                               32'h0, 32'hFFFF_FFFB};
      logic [31:0] el  [6] = '{32'hFFFF_FFFA, 32'h0000_0001, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                               32'h8000_0000, 32'hFFFF_FFFF};
      int          lt  [6] = '{5, 5, 33, 33, 33, 33};
      int nb; bit chg;
      for (int i = 0; i < 6; i++) begin
         issue(ops[i], as[i], bs[i], nb, chg);
         n_cmp++; if (nb != lt[i]) begin n_bad++; $display("FAIL dir%0d_latency got %0d want %0d", i, nb, lt[i]); end
         n_cmp++; if (chg) begin n_bad++; $display("FAIL dir%0d_hilo_early got changed want stable", i); end
         n_cmp++; if (hi !== eh[i]) begin n_bad++; $display("FAIL dir%0d_hi got %h want %h", i, hi, eh[i]); end
         n_cmp++; if (lo !== el[i]) begin n_bad++; $display("FAIL dir%0d_lo got %h want %h", i, lo, el[i]); end
         mhl = {eh[i], el[i]};
      end
   endtask

   task automatic test_mthi_mtlo;
      @(negedge clk);
      start = 1'b1; op = 3'd4; a = 32'h1234_5678;
      @(posedge clk); #1;
      n_cmp++; if (hi !== 32'h1234_5678) begin n_bad++; $display("FAIL mthi_hi got %h want 12345678", hi); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mthi_busy got %b want 0", busy); end
      op = 3'd5; a = 32'h9ABC_DEF0;
      @(posedge clk); #1;
      start = 1'b0;
      n_cmp++; if (lo !== 32'h9ABC_DEF0) begin n_bad++; $display("FAIL mtlo_lo got %h want 9abcdef0", lo); end
      n_cmp++; if (hi !== 32'h1234_5678) begin n_bad++; $display("FAIL mtlo_hi got %h want 12345678", hi); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mtlo_busy got %b want 0", busy); end
      mhl = {32'h1234_5678, 32'h9ABC_DEF0};
   endtask

   task automatic test_ignore_busy;
      int nb;
      @(negedge clk);
      start = 1'b1; op = 3'd0; a = 32'd5; b = 32'd6;
      @(posedge clk); #1;
      op = 3'd2; a = 32'd100; b = 32'd7;   // start stays high throughout busy
      nb = 0;
      while (busy === 1'b1 && nb < 200) begin nb++; @(posedge clk); #1; end
      start = 1'b0;
      n_cmp++; if (nb != MC) begin n_bad++; $display("FAIL ignore_latency got %0d want %0d", nb, MC); end
      n_cmp++; if ({hi, lo} !== 64'd30) begin n_bad++; $display("FAIL ignore_result got %h want 30", {hi, lo}); end
      @(posedge clk); #1;
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ignore_late_accept got %b want 0", busy); end
      mhl = 64'd30;
   endtask

   task automatic test_reset_mid;
      bit bad;
      @(negedge clk);
      start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) begin @(posedge clk); #1; end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rstmid_busy10 got %b want 1", busy); end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got %b want 0", busy); end
      n_cmp++; if ({hi, lo} !== 64'd0) begin n_bad++; $display("FAIL rstmid_hilo got %h want 0", {hi, lo}); end
      bad = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) bad = 1'b1;
      end
      n_cmp++; if (bad) begin n_bad++; $display("FAIL rstmid_late_commit got activity want none"); end
      mhl = '0;
   endtask

   task automatic test_madd;
      int nb; bit chg;
      issue(3'd4, 32'd0, 32'd0, nb, chg);
      issue(3'd5, 32'd10, 32'd0, nb, chg);
      issue(3'd6, 32'd3, 32'd4, nb, chg);
`ifdef MUL_DIV_MADD_EN
      n_cmp++; if (nb != MC) begin n_bad++; $display("FAIL madd_latency got %0d want %0d", nb, MC); end
      n_cmp++; if (lo !== 32'd22) begin n_bad++; $display("FAIL madd_lo got %0d want 22", lo); end
      mhl = 64'd22;
`else
      n_cmp++; if (nb != 0) begin n_bad++; $display("FAIL madd_busy got %0d want 0", nb); end
      n_cmp++; if (lo !== 32'd10) begin n_bad++; $display("FAIL madd_lo got %0d want 10", lo); end
      mhl = 64'd10;
`endif
      n_cmp++; if (hi !== 32'd0) begin n_bad++; $display("FAIL madd_hi got %h want 0", hi); end
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         5: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   // Back-to-back: issue() returns in the first idle cycle, so the next start
   // lands on the very next edge with no bubble.
   task automatic test_random;
      int nb; bit chg;
      logic [2:0] o; logic [31:0] x, y; logic [63:0] exp;
      for (int i = 0; i < 40; i++) begin
         o = 3'($urandom_range(0, 7));
         x = pick(); y = pick();
         exp = model(o, x, y, mhl);
         issue(o, x, y, nb, chg);
         n_cmp++; if (nb != lat_of(o)) begin n_bad++; $display("FAIL rnd%0d_latency op=%0d got %0d want %0d", i, o, nb, lat_of(o)); end
         n_cmp++; if ({hi, lo} !== exp) begin n_bad++; $display("FAIL rnd%0d_hilo op=%0d a=%h b=%h got %h want %h", i, o, x, y, {hi, lo}, exp); end
         n_cmp++; if (chg) begin n_bad++; $display("FAIL rnd%0d_hilo_early op=%0d got changed want stable", i, o); end
         mhl = exp;
      end
   endtask

   initial begin
      test_reset;
      test_directed;
      test_mthi_mtlo;
      test_ignore_busy;
      test_reset_mid;
      test_madd;
      test_random;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
